// File: rtl/bus_pkg.sv
// Shared definitions for the two-master, three-slave serial bus arbiter:
// FSM state encoding, slave-select codes and small decode helpers.
package bus_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int NUM_SLAVES  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_XFER    = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_e;

    // Top two address bits of every frame select the target slave.
    typedef enum logic [1:0] {
        SEL_SLAVE0 = 2'b00,
        SEL_SLAVE1 = 2'b01,
        SEL_SLAVE2 = 2'b10,
        SEL_NONE   = 2'b11
    } slave_sel_e;

    function automatic logic [NUM_SLAVES-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_SLAVES-1:0] oh;
        oh = '0;
        case (sel)
            SEL_SLAVE0: oh = 3'b001;
            SEL_SLAVE1: oh = 3'b010;
            SEL_SLAVE2: oh = 3'b100;
            default:    oh = 3'b000;
        endcase
        return oh;
    endfunction

    // With both masters requesting, the favoured one wins; otherwise the lone requester.
    function automatic logic rr_pick(input logic [NUM_MASTERS-1:0] req, input logic favour);
        logic winner;
        if (&req) begin
            winner = favour;
        end else begin
            winner = req[1];
        end
        return winner;
    endfunction

endpackage

// File: rtl/bus_fwd_pipe.sv
// Two-stage register pipeline carrying the owner's serial address, data,
// write-enable and valid towards the slaves; flush clears both stages at once.
module bus_fwd_pipe (
    input  logic clock,
    input  logic resetn,
    input  logic flush,
    input  logic addr_in,
    input  logic data_in,
    input  logic we_in,
    input  logic valid_in,
    output logic addr_out,
    output logic data_out,
    output logic we_out,
    output logic valid_out
);

    logic [3:0] stage1_q, stage1_d;
    logic [3:0] stage2_q, stage2_d;

    always_comb begin
        stage1_d = flush ? 4'b0000 : {addr_in, data_in, we_in, valid_in};
        stage2_d = flush ? 4'b0000 : stage1_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stage1_q <= 4'b0000;
            stage2_q <= 4'b0000;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign {addr_out, data_out, we_out, valid_out} = stage2_q;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one of two serial masters access to three slaves.
// Define ARB_TIMEOUT_EN to add an ownership limit of TIMEOUT_CYC cycles.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int          ADDR_W      = 14,
    parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_MASTERS-1:0] m_bus_req,
    output logic [NUM_MASTERS-1:0] m_bus_ready,
    input  logic [NUM_MASTERS-1:0] m_addr_tx,
    input  logic [NUM_MASTERS-1:0] m_data_tx,
    input  logic [NUM_MASTERS-1:0] m_valid_s,
    input  logic [NUM_MASTERS-1:0] m_write_en,
    output logic                   m_data_rx,
    output logic [NUM_MASTERS-1:0] m_slave_valid,
    output logic                   s_addr_tx,
    output logic                   s_data_tx,
    output logic                   s_write_en,
    output logic [NUM_SLAVES-1:0]  s_valid,
    input  logic [NUM_SLAVES-1:0]  s_data_rx,
    input  logic [NUM_SLAVES-1:0]  s_slave_valid,
    output logic                   owner,
    output logic                   busy,
    output logic                   dec_err
);

    arb_state_e             state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   rr_favour_q, rr_favour_d;
    logic [NUM_MASTERS-1:0] ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   dec_err_q, dec_err_d;
    logic [1:0]             sel_q, sel_d;
    logic                   sel_ok_q, sel_ok_d;
    logic                   rx_data_q, rx_data_d;
    logic [NUM_MASTERS-1:0] rx_vld_q, rx_vld_d;

    logic       own_req, own_addr, own_data, own_we, own_valid;
    logic [1:0] sel_shift;
    logic       slave_rx_data, slave_rx_valid;
    logic       tmo_hit;
    logic       fwd_flush, fwd_addr, fwd_data, fwd_we, fwd_valid;

    // ADDR_W only describes the master-side frame; decode needs just the top two bits.
    logic unused_params;
    assign unused_params = ^{ADDR_W, TIMEOUT_CYC};

    assign own_req   = m_bus_req[owner_q];
    assign own_addr  = m_addr_tx[owner_q];
    assign own_data  = m_data_tx[owner_q];
    assign own_we    = m_write_en[owner_q];
    assign own_valid = m_valid_s[owner_q];

`ifdef ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Counter restarts at zero on every grant because it idles at zero when not busy.
    always_comb begin
        tmo_cnt_d = busy_q ? (tmo_cnt_q + 16'd1) : 16'd0;
        tmo_hit   = busy_q && (tmo_cnt_q == (TIMEOUT_CYC - 16'd1));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        slave_rx_data  = 1'b0;
        slave_rx_valid = 1'b0;
        case (sel_q)
            SEL_SLAVE0: begin
                slave_rx_data  = s_data_rx[0];
                slave_rx_valid = s_slave_valid[0];
            end
            SEL_SLAVE1: begin
                slave_rx_data  = s_data_rx[1];
                slave_rx_valid = s_slave_valid[1];
            end
            SEL_SLAVE2: begin
                slave_rx_data  = s_data_rx[2];
                slave_rx_valid = s_slave_valid[2];
            end
            default: begin
                slave_rx_data  = 1'b0;
                slave_rx_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_favour_d = rr_favour_q;
        sel_d       = sel_q;
        sel_ok_d    = sel_ok_q;
        dec_err_d   = 1'b0;
        sel_shift   = {sel_q[0], own_addr};

        case (state_q)
            ST_IDLE: begin
                if (|m_bus_req) begin
                    owner_d     = rr_pick(m_bus_req, rr_favour_q);
                    rr_favour_d = ~owner_d;
                    sel_d       = 2'b00;
                    sel_ok_d    = 1'b0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!own_req) begin
                    state_d = ST_RELEASE;
                end else if (own_valid) begin
                    sel_d   = sel_shift;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!own_req) begin
                    state_d = ST_RELEASE;
                end else if (own_valid) begin
                    sel_d     = sel_shift;
                    sel_ok_d  = (sel_shift != SEL_NONE);
                    dec_err_d = (sel_shift == SEL_NONE);
                    state_d   = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!own_req) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                sel_d    = 2'b00;
                sel_ok_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tmo_hit) begin
            state_d   = ST_RELEASE;
            dec_err_d = 1'b1;
        end

        if (state_d == ST_RELEASE) begin
            sel_ok_d = 1'b0;
        end

        busy_d  = (state_d == ST_GRANT) || (state_d == ST_DECODE) || (state_d == ST_XFER);
        ready_d = '0;
        if (busy_d) begin
            ready_d[owner_d] = 1'b1;
        end

        // Read data is only returned while the transfer carries on into the next cycle.
        rx_data_d = 1'b0;
        rx_vld_d  = '0;
        if ((state_q == ST_XFER) && (state_d == ST_XFER) && sel_ok_q) begin
            rx_data_d         = slave_rx_data;
            rx_vld_d[owner_q] = slave_rx_valid;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            rr_favour_q <= 1'b0;
            ready_q     <= '0;
            busy_q      <= 1'b0;
            dec_err_q   <= 1'b0;
            sel_q       <= 2'b00;
            sel_ok_q    <= 1'b0;
            rx_data_q   <= 1'b0;
            rx_vld_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_favour_q <= rr_favour_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            dec_err_q   <= dec_err_d;
            sel_q       <= sel_d;
            sel_ok_q    <= sel_ok_d;
            rx_data_q   <= rx_data_d;
            rx_vld_q    <= rx_vld_d;
        end
    end

    assign fwd_flush = (state_d == ST_RELEASE);

    bus_fwd_pipe u_fwd_pipe (
        .clock     (clock),
        .resetn    (resetn),
        .flush     (fwd_flush),
        .addr_in   (busy_q & own_addr),
        .data_in   (busy_q & own_data),
        .we_in     (busy_q & own_we),
        .valid_in  (busy_q & own_valid),
        .addr_out  (fwd_addr),
        .data_out  (fwd_data),
        .we_out    (fwd_we),
        .valid_out (fwd_valid)
    );

    // The select register is complete exactly when the first frame bit leaves the pipe.
    always_comb begin
        s_valid = '0;
        if (sel_ok_q && fwd_valid) begin
            s_valid = sel_onehot(sel_q);
        end
    end

    assign s_addr_tx     = fwd_addr;
    assign s_data_tx     = fwd_data;
    assign s_write_en    = fwd_we;
    assign m_bus_ready   = ready_q;
    assign m_data_rx     = rx_data_q;
    assign m_slave_valid = rx_vld_q;
    assign owner         = owner_q;
    assign busy          = busy_q;
    assign dec_err       = dec_err_q;

endmodule
